// File: rtl/conv1d_param.sv
// conv1d_param -- command-driven 1-D convolution engine with an int8-style
// multiply-accumulate datapath and a quantising output stage.
//
// The host talks to the block through a single command port. Input and filter
// samples are written into two byte buffers. Runtime parameters are set with
// their own commands. A start command then runs LANES multiply-accumulates per
// cycle over kernel_len*input_depth samples. The accumulator is then passed to
// the quantiser (conv1d_quant), and the quantised word is latched.
//
// The input buffer is read as a ring. Reading starts at start_x*input_depth.
// Each lane that reaches or passes the end of the window wraps back by one
// window length.
//
// Ports (conv1d_param):
//   clk                  rising-edge clock for all state
//   rst_n                asynchronous active-low reset
//   en                   command strobe; cmd/inp0/inp1 sampled only when high
//   cmd[6:0]             command code
//   inp0[INT32_SIZE-1:0] byte address for buffer writes
//   inp1[INT32_SIZE-1:0] value / parameter operand
//   ret[INT32_SIZE-1:0]  registered result, updated the cycle after a command
//   output_buffer_valid  constant 1
//
// Ports (conv1d_quant):
//   clk, rst_n           clock and asynchronous active-low reset
//   flush                drops any computation in flight (abort)
//   start                one-cycle pulse; samples acc and the parameters
//   acc .. out_offset    accumulator and quantisation parameters
//   ret_valid, ret       one-cycle valid pulse with the clamped result

module conv1d_quant #(
  parameter int W = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  input  logic                start,
  input  logic signed [W-1:0] acc,
  input  logic signed [W-1:0] bias,
  input  logic signed [W-1:0] mult,
  input  logic        [W-1:0] shift,
  input  logic signed [W-1:0] act_min,
  input  logic signed [W-1:0] act_max,
  input  logic signed [W-1:0] out_offset,
  output logic                ret_valid,
  output logic signed [W-1:0] ret
);
  localparam int SW = $clog2(2 * W);

  logic signed [2*W-1:0] prod_q;
  logic                  v1_q;
  logic signed [W-1:0]   biased;
  logic signed [2*W-1:0] biased_ext;
  logic signed [2*W-1:0] mult_ext;
  logic signed [2*W-1:0] shifted;
  logic        [SW-1:0]  shift_amt;
  logic signed [W-1:0]   y;
  logic signed [W-1:0]   y_clamped;

  // Quantisation rule: y = ((acc + bias) * mult) >>> shift[SW-1:0].
  // The product is full-width signed and the shift is arithmetic.
  // The low W bits of y get out_offset added, and the sum is clamped
  // to [act_min, act_max].
  // NOTE: every always_comb output gets a value on every path (defaults
  // first, then overrides); a path that leaves one unassigned infers a latch.
  always_comb begin
    biased     = acc + bias;
    biased_ext = biased;   // signed-to-wider assignment sign-extends
    mult_ext   = mult;
    shift_amt  = SW'(shift);
    shifted    = prod_q >>> shift_amt;
    y          = W'(shifted) + out_offset;
    y_clamped  = y;
    if (y < act_min)      y_clamped = act_min;
    else if (y > act_max) y_clamped = act_max;
  end

  // NOTE: sequential state is written with non-blocking assignments only,
  // so every register samples its inputs as they were before the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_q    <= '0;
      v1_q      <= 1'b0;
      ret_valid <= 1'b0;
      ret       <= '0;
    end else begin
      v1_q      <= start && !flush;
      ret_valid <= v1_q && !flush;
      if (start) prod_q <= biased_ext * mult_ext;
      if (v1_q)  ret    <= y_clamped;
    end
  end
endmodule

module conv1d_param #(
  parameter int BYTE_SIZE          = 8,
  parameter int INT32_SIZE         = 32,
  parameter int LANES              = 8,
  parameter int MAX_KERNEL_LENGTH  = 16,
  parameter int MAX_INPUT_CHANNELS = 128
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [6:0]            cmd,
  input  logic [INT32_SIZE-1:0] inp0,
  input  logic [INT32_SIZE-1:0] inp1,
  output logic [INT32_SIZE-1:0] ret,
  output logic                  output_buffer_valid
);
  localparam int BUF_SIZE = MAX_KERNEL_LENGTH * MAX_INPUT_CHANNELS;
  localparam int IW       = $clog2(BUF_SIZE);

  localparam logic [6:0] CMD_INFO       = 7'd0;
  localparam logic [6:0] CMD_WR_INPUT   = 7'd1;
  localparam logic [6:0] CMD_WR_FILTER  = 7'd2;
  localparam logic [6:0] CMD_IN_OFFSET  = 7'd3;
  localparam logic [6:0] CMD_IN_DEPTH   = 7'd5;
  localparam logic [6:0] CMD_START      = 7'd6;
  localparam logic [6:0] CMD_RESULT     = 7'd7;
  localparam logic [6:0] CMD_START_X    = 7'd8;
  localparam logic [6:0] CMD_STATUS     = 7'd9;
  localparam logic [6:0] CMD_RAW_ACC    = 7'd10;
  localparam logic [6:0] CMD_KERNEL_LEN = 7'd11;
  localparam logic [6:0] CMD_BIAS       = 7'd12;
  localparam logic [6:0] CMD_OUT_MULT   = 7'd13;
  localparam logic [6:0] CMD_OUT_SHIFT  = 7'd14;
  localparam logic [6:0] CMD_ACT_MIN    = 7'd15;
  localparam logic [6:0] CMD_ACT_MAX    = 7'd16;
  localparam logic [6:0] CMD_OUT_OFFSET = 7'd17;
  localparam logic [6:0] CMD_ABORT      = 7'd19;

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_QUANT} state_t;

  state_t state;

  // Sample buffers.
  logic signed [BYTE_SIZE-1:0] in_buf  [0:BUF_SIZE-1];
  logic signed [BYTE_SIZE-1:0] flt_buf [0:BUF_SIZE-1];

  // Runtime parameters.
  logic signed [INT32_SIZE-1:0] input_offset;
  logic        [INT32_SIZE-1:0] input_depth;
  logic        [INT32_SIZE-1:0] start_x;
  logic        [INT32_SIZE-1:0] kernel_len;
  logic signed [INT32_SIZE-1:0] bias;
  logic signed [INT32_SIZE-1:0] out_mult;
  logic        [INT32_SIZE-1:0] out_shift;
  logic signed [INT32_SIZE-1:0] act_min;
  logic signed [INT32_SIZE-1:0] act_max;
  logic signed [INT32_SIZE-1:0] out_offset;

  // Computation state.
  logic signed [INT32_SIZE-1:0] acc;
  logic signed [INT32_SIZE-1:0] acc_done;   // acc as it stood when MAC finished
  logic        [INT32_SIZE-1:0] res_q;      // last quantised result
  logic        [INT32_SIZE-1:0] kernel_addr;
  logic        [INT32_SIZE-1:0] input_addr;
  logic        [INT32_SIZE-1:0] total;
  logic                         done;
  logic                         error;
  logic                         q_start;

  logic                         busy;
  logic                         abort;
  logic                         cfg_cmd;
  logic                         start_bad;
  logic        [INT32_SIZE-1:0] total_calc;
  logic        [INT32_SIZE-1:0] start_addr;
  logic        [INT32_SIZE-1:0] input_addr_next;
  logic signed [INT32_SIZE-1:0] lane_sum;
  logic        [INT32_SIZE-1:0] ret_next;
  logic        [INT32_SIZE-1:0] wr_addr [4];
  logic                         wr_input;
  logic                         wr_filter;
  logic                         q_valid;
  logic signed [INT32_SIZE-1:0] q_ret;

  assign output_buffer_valid = 1'b1;
  assign busy  = (state != S_IDLE);
  assign abort = en && (cmd == CMD_ABORT);

  // Commands that reconfigure the block; while busy these are refused.
  always_comb begin
    cfg_cmd = 1'b0;
    case (cmd)
      CMD_WR_INPUT, CMD_WR_FILTER, CMD_IN_OFFSET, CMD_IN_DEPTH, CMD_START,
      CMD_START_X, CMD_KERNEL_LEN, CMD_BIAS, CMD_OUT_MULT, CMD_OUT_SHIFT,
      CMD_ACT_MIN, CMD_ACT_MAX, CMD_OUT_OFFSET: cfg_cmd = 1'b1;
      default: ;
    endcase
  end

  // Start validation. When both size limits hold, the product cannot overflow.
  always_comb begin
    total_calc = kernel_len * input_depth;
    start_addr = start_x * input_depth;
    start_bad  = (total_calc == '0)
              || ((total_calc & INT32_SIZE'(LANES - 1)) != '0)
              || (kernel_len  > INT32_SIZE'(MAX_KERNEL_LENGTH))
              || (input_depth > INT32_SIZE'(MAX_INPUT_CHANNELS));
  end

  // One MAC step. Each lane wraps its own input index, so a window that
  // starts mid-ring reads the correct samples in a single cycle.
  always_comb begin
    logic        [INT32_SIZE-1:0] ia;
    logic        [IW-1:0]         ka;
    logic signed [INT32_SIZE-1:0] f_ext;
    logic signed [INT32_SIZE-1:0] x_ext;
    lane_sum = '0;
    ia       = '0;
    ka       = '0;
    f_ext    = '0;
    x_ext    = '0;
    for (int l = 0; l < LANES; l++) begin
      ka = IW'(kernel_addr + INT32_SIZE'(l));
      ia = input_addr + INT32_SIZE'(l);
      if (ia >= total) ia = ia - total;
      f_ext    = flt_buf[ka];
      x_ext    = in_buf[IW'(ia)];
      lane_sum = lane_sum + f_ext * (x_ext + input_offset);
    end
    input_addr_next = input_addr + INT32_SIZE'(LANES);
    if (input_addr_next >= total) input_addr_next = input_addr_next - total;
  end

  // Read-back mux.
  always_comb begin
    ret_next = '0;
    case (cmd)
      CMD_INFO:    ret_next = INT32_SIZE'({8'(LANES), 8'(MAX_KERNEL_LENGTH),
                                           16'(MAX_INPUT_CHANNELS)});
      CMD_RESULT:  ret_next = res_q;
      CMD_STATUS:  ret_next = INT32_SIZE'({error, busy, done});
      CMD_RAW_ACC: ret_next = busy ? acc_done : acc;
      default: ;
    endcase
  end

  // Buffer writes: four little-endian bytes. Bytes past the end are dropped.
  assign wr_input  = en && (cmd == CMD_WR_INPUT)  && !busy;
  assign wr_filter = en && (cmd == CMD_WR_FILTER) && !busy;

  always_comb begin
    for (int k = 0; k < 4; k++) wr_addr[k] = inp0 + INT32_SIZE'(k);
  end

  // NOTE: the sample buffers have no reset; their contents are undefined after
  // reset. Leaving out the reset keeps them plain storage instead of a large
  // reset-loaded register file.
  always_ff @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (wr_input && (wr_addr[k] < INT32_SIZE'(BUF_SIZE)))
        in_buf[IW'(wr_addr[k])]  <= BYTE_SIZE'(inp1[8*k +: 8]);
      if (wr_filter && (wr_addr[k] < INT32_SIZE'(BUF_SIZE)))
        flt_buf[IW'(wr_addr[k])] <= BYTE_SIZE'(inp1[8*k +: 8]);
    end
  end

  // Control FSM and all architectural registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      ret          <= '0;
      acc          <= '0;
      acc_done     <= '0;
      res_q        <= '0;
      kernel_addr  <= '0;
      input_addr   <= '0;
      total        <= '0;
      done         <= 1'b1;
      error        <= 1'b0;
      q_start      <= 1'b0;
      input_offset <= '0;
      input_depth  <= '0;
      start_x      <= '0;
      kernel_len   <= INT32_SIZE'(MAX_KERNEL_LENGTH);
      bias         <= '0;
      out_mult     <= '0;
      out_shift    <= '0;
      act_min      <= '0;
      act_max      <= '0;
      out_offset   <= '0;
    end else begin
      q_start <= 1'b0;
      if (en) ret <= ret_next;

      if (abort) begin
        // Abort leaves acc as it was and drops the quantiser pipeline.
        state <= S_IDLE;
        done  <= 1'b1;
      end else begin
        case (state)
          S_IDLE: begin
            if (en) begin
              case (cmd)
                CMD_IN_OFFSET:  input_offset <= inp1;
                CMD_IN_DEPTH:   input_depth  <= inp1;
                CMD_START_X:    start_x      <= inp1;
                CMD_KERNEL_LEN: kernel_len   <= inp1;
                CMD_BIAS:       bias         <= inp1;
                CMD_OUT_MULT:   out_mult     <= inp1;
                CMD_OUT_SHIFT:  out_shift    <= inp1;
                CMD_ACT_MIN:    act_min      <= inp1;
                CMD_ACT_MAX:    act_max      <= inp1;
                CMD_OUT_OFFSET: out_offset   <= inp1;
                CMD_START: begin
                  if (start_bad) begin
                    error <= 1'b1;
                  end else begin
                    acc         <= '0;
                    done        <= 1'b0;
                    error       <= 1'b0;
                    kernel_addr <= '0;
                    input_addr  <= start_addr;
                    total       <= total_calc;
                    state       <= S_MAC;
                  end
                end
                default: ;
              endcase
            end
          end

          S_MAC: begin
            if (en && cfg_cmd) error <= 1'b1;
            acc         <= acc + lane_sum;
            kernel_addr <= kernel_addr + INT32_SIZE'(LANES);
            input_addr  <= input_addr_next;
            if (kernel_addr + INT32_SIZE'(LANES) >= total) begin
              acc_done <= acc + lane_sum;
              q_start  <= 1'b1;
              state    <= S_QUANT;
            end
          end

          S_QUANT: begin
            if (en && cfg_cmd) error <= 1'b1;
            if (q_valid) begin
              res_q <= q_ret;
              done  <= 1'b1;
              state <= S_IDLE;
            end
          end

          default: state <= S_IDLE;
        endcase
      end
    end
  end

  conv1d_quant #(.W(INT32_SIZE)) u_quant (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (abort),
    .start      (q_start),
    .acc        (acc),
    .bias       (bias),
    .mult       (out_mult),
    .shift      (out_shift),
    .act_min    (act_min),
    .act_max    (act_max),
    .out_offset (out_offset),
    .ret_valid  (q_valid),
    .ret        (q_ret)
  );
endmodule
